// File: rtl/spi_flash_responder.sv
// SPI mode-0 read-only flash emulator: decodes READ + 24-bit address and streams bytes from an
// internal array loaded through a parallel backdoor. Define SPI_FAST_READ_EN to also accept 0x0B.
module spi_flash_responder #(
  parameter int          ADDR_W      = 8,
  parameter logic [7:0]  CMD_READ    = 8'h03,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              busy,
  output logic              cmd_err
);

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
`ifdef SPI_FAST_READ_EN
    ST_DUMMY,
`endif
    ST_DATA,
    ST_IGNORE
  } state_e;

  // Synchronisers; cs resets high so an asserted cs_n during reset is not seen as busy.
  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   sclk_d_q;
  logic                   cs_s, sclk_s, mosi_s, rise, fall;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      sclk_d_q    <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_d_q    <= sclk_s;
    end
  end

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_d_q;
  assign fall   = ~sclk_s & sclk_d_q;

  logic [7:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  // NOTE: the byte array has no reset; its contents only come from the backdoor port.
  always_ff @(posedge clk) begin
    if (load_en && !busy) mem[load_addr] <= load_data;
  end

  state_e            state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        shift_out_q, shift_out_d;
  logic              miso_q, miso_d, oe_q, oe_d, err_q, err_d;
`ifdef SPI_FAST_READ_EN
  logic              fast_q, fast_d;
`endif

  logic [7:0]        opcode;
  logic [ADDR_W-1:0] addr_shift, addr_inc;

  assign opcode     = {cmd_q, mosi_s};
  assign addr_shift = {addr_q[ADDR_W-2:0], mosi_s};
  assign addr_inc   = addr_q + 1'b1;

  // The array is read at three points: end of address, end of dummy, and each byte boundary.
  always_comb begin
    case (state_q)
      ST_ADDR: rd_addr = addr_shift;
      ST_DATA: rd_addr = addr_inc;
      default: rd_addr = addr_q;
    endcase
  end
  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      shift_out_q <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      err_q       <= 1'b0;
`ifdef SPI_FAST_READ_EN
      fast_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      shift_out_q <= shift_out_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      err_q       <= err_d;
`ifdef SPI_FAST_READ_EN
      fast_q      <= fast_d;
`endif
    end
  end

  // NOTE: every next-state signal is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    shift_out_d = shift_out_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    err_d       = 1'b0;
`ifdef SPI_FAST_READ_EN
    fast_d      = fast_q;
`endif

    if (cs_s) begin
      // Deselect aborts anything in flight, including a partial opcode (no error).
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      miso_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_CMD;
          bit_cnt_d = '0;
        end
        ST_CMD: if (rise) begin
          cmd_d     = opcode[6:0];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            if (opcode == CMD_READ) begin
              state_d = ST_ADDR;
`ifdef SPI_FAST_READ_EN
              fast_d  = 1'b0;
            end else if (opcode == CMD_FAST_READ) begin
              state_d = ST_ADDR;
              fast_d  = 1'b1;
`endif
            end else begin
              err_d   = 1'b1;
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR: if (rise) begin
          addr_d    = addr_shift;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d   = '0;
            shift_out_d = rd_data;
            state_d     = ST_DATA;
`ifdef SPI_FAST_READ_EN
            if (fast_q) state_d = ST_DUMMY;
`endif
          end
        end
`ifdef SPI_FAST_READ_EN
        ST_DUMMY: if (rise) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d   = '0;
            shift_out_d = rd_data;
            state_d     = ST_DATA;
          end
        end
`endif
        ST_DATA: if (fall) begin
          // shift_out_q[7] is always the next bit to present; the last bit of a byte reloads.
          oe_d        = 1'b1;
          miso_d      = shift_out_q[7];
          shift_out_d = {shift_out_q[6:0], 1'b0};
          bit_cnt_d   = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d   = '0;
            addr_d      = addr_inc;
            shift_out_d = rd_data;
          end
        end
        ST_IGNORE: oe_d = 1'b0;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign busy        = ~cs_s;
  assign cmd_err     = err_q;

endmodule
